virtual_uart_host: RTL and testbench

Host-side AXI-lite initiator that services the `virtual_uart` register block from the opposite end. It runs in place of the XDMA host for simulation and self-hosted builds. On the XDMA-directed interrupt it reads the TX register, hands the byte out on a byte stream and acknowledges the interrupt. It accepts bytes on an input stream and writes them into the RX register once the status register shows RX empty. It sits on the crossbar as a master; its address window targets the virtual UART's base address.

---
 rtl/virtual_uart_host.sv | 226 ++++++++++++++++++++++
 tb/tb_virtual_uart_host.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/virtual_uart_host.sv
// virtual_uart_host: AXI-lite initiator that drains the virtual UART TX register on interrupt and feeds RX bytes into it.
// Latency: each AXI request issues one cycle after its state is entered; tx_valid_o/rx_ready_o follow the R/B handshake by one cycle.
// Backpressure: stalls indefinitely on any AXI channel; holds tx_valid_o until tx_ready_i and defers further TX service meanwhile.
module virtual_uart_host #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                POLL_GAP       = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic                          irq_i,
    output logic [7:0]                    tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_valid_i,
    output logic                          rx_ready_o,
    output logic                          err_o,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_RX     = AXI_ADDR_WIDTH'(32'h00);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_TX     = AXI_ADDR_WIDTH'(32'h04);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_STATUS = AXI_ADDR_WIDTH'(32'h08);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_CTRL   = AXI_ADDR_WIDTH'(32'h0C);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_ACK    = AXI_ADDR_WIDTH'(32'h10);
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [3:0] {
        INIT_W, INIT_B, IDLE, TX_AR, TX_R, ACK_W, ACK_B,
        ST_AR, ST_R, RX_W, RX_B, GAP
    } state_t;

    state_t                      r_state;
    logic                        r_issued;
    logic [GAP_W-1:0]            r_cnt;
    logic [7:0]                  r_rx_byte;
    logic [7:0]                  r_tx_data;
    logic                        r_tx_valid;
    logic                        r_rx_ready;
    logic                        r_err;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic                        r_awvalid;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                        r_wvalid;
    logic                        r_bready;
    logic [AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic                        r_arvalid;
    logic                        r_rready;

    logic [AXI_ADDR_WIDTH-1:0]   w_wr_addr;
    logic [AXI_DATA_WIDTH-1:0]   w_wr_data;
    logic [AXI_ADDR_WIDTH-1:0]   w_rd_addr;
    logic                        w_aw_ok;
    logic                        w_w_ok;
    logic                        w_unused;

    // AW/W each count as done once accepted; this cycle's handshake counts too
    assign w_aw_ok  = !r_awvalid || m_axi_awready;
    assign w_w_ok   = !r_wvalid  || m_axi_wready;
    assign w_unused = ^m_axi_rdata[AXI_DATA_WIDTH-1:8];

    // Address and payload of the access the current state is about to launch
    always_comb begin
        w_wr_addr = BASE_ADDR + OFF_CTRL;
        w_wr_data = AXI_DATA_WIDTH'(1);
        w_rd_addr = BASE_ADDR + OFF_STATUS;
        case (r_state)
            ACK_W: begin
                w_wr_addr = BASE_ADDR + OFF_ACK;
                w_wr_data = '0;
            end
            RX_W: begin
                w_wr_addr = BASE_ADDR + OFF_RX;
                w_wr_data = {{(AXI_DATA_WIDTH-8){1'b0}}, r_rx_byte};
            end
            TX_AR:   w_rd_addr = BASE_ADDR + OFF_TX;
            default: ;
        endcase
    end

    // Control FSM with all AXI and stream outputs registered
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= INIT_W;
            r_issued   <= 1'b0;
            r_cnt      <= '0;
            r_rx_byte  <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_err      <= 1'b0;
            r_awaddr   <= '0;
            r_awvalid  <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            r_rx_ready <= 1'b0;
            if (r_tx_valid && tx_ready_i) begin
                r_tx_valid <= 1'b0;
            end
            case (r_state)
                INIT_W, ACK_W, RX_W: begin
                    if (!r_issued) begin
                        r_awaddr  <= w_wr_addr;
                        r_wdata   <= w_wr_data;
                        r_wstrb   <= '1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_issued  <= 1'b1;
                    end else begin
                        if (m_axi_awready) r_awvalid <= 1'b0;
                        if (m_axi_wready)  r_wvalid  <= 1'b0;
                        if (w_aw_ok && w_w_ok) begin
                            r_bready <= 1'b1;
                            r_issued <= 1'b0;
                            r_state  <= (r_state == INIT_W) ? INIT_B :
                                        (r_state == ACK_W)  ? ACK_B  : RX_B;
                        end
                    end
                end
                INIT_B, ACK_B, RX_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) r_err <= 1'b1;
                        if (r_state == RX_B) r_rx_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                TX_AR, ST_AR: begin
                    if (!r_issued) begin
                        r_araddr  <= w_rd_addr;
                        r_arvalid <= 1'b1;
                        r_issued  <= 1'b1;
                    end else if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_issued  <= 1'b0;
                        r_state   <= (r_state == TX_AR) ? TX_R : ST_R;
                    end
                end
                TX_R: begin
                    if (m_axi_rvalid) begin
                        r_rready   <= 1'b0;
                        r_tx_data  <= m_axi_rdata[7:0];
                        r_tx_valid <= 1'b1;
                        if (m_axi_rresp != 2'b00) r_err <= 1'b1;
                        r_state    <= ACK_W;
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (m_axi_rresp != 2'b00) r_err <= 1'b1;
                        if (!m_axi_rdata[0]) begin
                            r_rx_byte <= rx_data_i;
                            r_state   <= RX_W;
                        end else begin
                            r_cnt   <= GAP_W'(POLL_GAP - 1);
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (irq_i || r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    // The byte just acknowledged by rx_ready_o is still presented this
                    // cycle; it is not mistaken for a new one.
                    if (irq_i && !r_tx_valid) begin
                        r_state <= TX_AR;
                    end else if (rx_valid_i && !r_rx_ready) begin
                        r_state <= ST_AR;
                    end
                end
                default: r_state <= INIT_W;
            endcase
        end
    end

    assign tx_data_o     = r_tx_data;
    assign tx_valid_o    = r_tx_valid;
    assign rx_ready_o    = r_rx_ready;
    assign err_o         = r_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_virtual_uart_host.sv
// Testbench for virtual_uart_host: behavioural virtual-UART slave plus a transaction-level model of expected traffic.
module tb_virtual_uart_host;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int unsigned PG   = 4;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    virtual_uart_host #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .BASE_ADDR(BASE), .POLL_GAP(PG)) dut (
        .clock_i(clk), .reset_ni(rst_n), .irq_i(irq),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .err_o(err),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    // Slave-side logs and knobs
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          ar_cyc_q[$];
    int          r_cyc_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] status_q[$];
    int          aw_delay, w_delay, aw_cnt, w_cnt;
    bit          aw_got, w_got, rd_busy, r_hold;
    logic [31:0] aw_addr_l, w_data_l, rd_addr_l;
    logic [3:0]  w_strb_l;
    logic [1:0]  bresp_force, rresp_force;
    logic [7:0]  tx_reg;
    int          irq_req, ack_cnt, b_cnt, rx_pulses, proto_err;
    int          cyc = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;

    int n_pass = 0;
    int n_total = 0;

    // The slave raises the interrupt per request and drops it when the ACK write's B is issued
    assign irq     = (irq_req != ack_cnt);
    assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
    assign wready  = wvalid && !w_got && (w_cnt >= w_delay);
    assign arready = arvalid && !rd_busy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00;
            rdata <= '0; rd_busy <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_addr_l <= awaddr; aw_cnt <= 0;
            end else if (awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; w_data_l <= wdata; w_strb_l <= wstrb; w_cnt <= 0;
            end else if (wvalid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= bresp_force;
                wr_q.push_back('{aw_addr_l, w_data_l, w_strb_l});
                if (aw_addr_l == BASE + 32'h10) ack_cnt <= ack_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                rd_q.push_back(araddr);
                ar_cyc_q.push_back(cyc);
                rd_busy   <= 1'b1;
                rd_addr_l <= araddr;
            end
            if (rd_busy && !rvalid && !r_hold) begin
                rvalid <= 1'b1;
                rresp  <= rresp_force;
                if (rd_addr_l == BASE + 32'h04) rdata <= {24'h0, tx_reg};
                else if (rd_addr_l == BASE + 32'h08) rdata <= (status_q.size() > 0) ? status_q.pop_front() : 32'h4;
                else rdata <= '0;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; rd_busy <= 1'b0; r_cyc_q.push_back(cyc);
            end
        end
    end

    // Stream monitors and AXI handshake-rule monitor
    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (rx_ready) rx_pulses <= rx_pulses + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            if ((p_awv && !p_awr && !awvalid) || (p_wv && !p_wr && !wvalid) || (p_arv && !p_arr && !arvalid))
                proto_err <= proto_err + 1;
            else if ((aw_got && awvalid) || (w_got && wvalid) || (bready && !(aw_got && w_got)))
                proto_err <= proto_err + 1;
            p_awv <= awvalid; p_awr <= awready; p_wv <= wvalid; p_wr <= wready;
            p_arv <= arvalid; p_arr <= arready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_wr(input int n, input string tag);
        int t = 0;
        while (wr_q.size() < n && t < 2000) begin @(negedge clk); t++; end
        chk(tag, 32'(wr_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rhs(input int n, input string tag);
        int t = 0;
        while (r_cyc_q.size() < n && t < 2000) begin @(negedge clk); t++; end
        chk(tag, 32'(r_cyc_q.size() >= n), 32'd1);
    endtask

    task automatic finish_rx(input string tag);
        int t = 0;
        do begin @(negedge clk); t++; end while (!rx_ready && t < 2000);
        rx_valid = 1'b0;
        chk(tag, {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic do_rx(input logic [7:0] b, input string tag);
        rx_data  = b;
        rx_valid = 1'b1;
        finish_rx(tag);
    endtask

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];

    initial begin
        int t, rd0, wr0, tx0, busy, wb;
        logic [7:0] b;
        rst_n = 1'b0; irq_req = 0; ack_cnt = 0; b_cnt = 0; rx_pulses = 0; proto_err = 0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; aw_delay = 0; w_delay = 0;
        bresp_force = 2'b00; rresp_force = 2'b00; r_hold = 1'b0; tx_reg = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_flags", {24'd0, awvalid, wvalid, bready, arvalid, rready, tx_valid, rx_ready, err}, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
        chk("rst_txdata", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // Init: single CONTROL write of 1 with full strobes, then one B
        wait_wr(1, "init_timeout");
        repeat (5) @(negedge clk);
        chk("init_addr", wr_q[0].addr, BASE + 32'h0C);
        chk("init_data", wr_q[0].data, 32'h1);
        chk("init_strb", {28'd0, wr_q[0].strb}, 32'hF);
        chk("init_bcnt", b_cnt, 1);
        chk("init_no_read", rd_q.size(), 0);

        // TX service with the byte held until accepted
        tx_reg = 8'h41; irq_req++;
        t = 0;
        while (!tx_valid && t < 2000) begin @(negedge clk); t++; end
        chk("tx_valid_up", {31'd0, tx_valid}, 32'd1);
        chk("tx_data", {24'd0, tx_data}, 32'h41);
        chk("tx_rd_addr", rd_q[0], BASE + 32'h04);
        wait_wr(2, "ack_timeout");
        repeat (4) @(negedge clk);
        chk("ack_addr", wr_q[1].addr, BASE + 32'h10);
        chk("ack_data", wr_q[1].data, 32'h0);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);

        // A new interrupt is not serviced while the previous byte waits
        tx_reg = 8'h42; irq_req++;
        repeat (20) @(negedge clk);
        chk("tx_busy_no_ar", rd_q.size(), 1);
        tx_ready = 1'b1;
        wait_wr(3, "ack2_timeout");
        repeat (20) @(negedge clk);
        chk("tx_q_len", tx_q.size(), 2);
        chk("tx_q0", {24'd0, tx_q[0]}, 32'h41);
        chk("tx_q1", {24'd0, tx_q[1]}, 32'h42);
        chk("no_double_service", rd_q.size(), 2);

        // RX delivery with STATUS showing RX empty
        do_rx(8'h5A, "rx_timeout");
        repeat (10) @(negedge clk);
        chk("rx_status_addr", rd_q[2], BASE + 32'h08);
        chk("rx_wr_addr", wr_q[3].addr, BASE);
        chk("rx_wr_data", wr_q[3].data, 32'h5A);
        chk("rx_pulse_once", rx_pulses, 1);
        chk("rx_no_repoll", rd_q.size(), 3);

        // RX busy: no write, POLL_GAP idle cycles, then a re-poll.
        // From the busy R handshake: PG GAP cycles, one IDLE, one ST_AR cycle before
        // arvalid, and the AR handshake cycle itself.
        status_q.push_back(32'h3);
        do_rx(8'hC3, "busy_timeout");
        repeat (5) @(negedge clk);
        chk("busy_repoll_addr", rd_q[4], BASE + 32'h08);
        chk("busy_gap_len", ar_cyc_q[4] - r_cyc_q[3], PG + 3);
        chk("busy_wr_count", wr_q.size(), 5);
        chk("busy_wr_data", wr_q[4].data, 32'hC3);

        // Interrupt raised during GAP is serviced before the re-poll
        status_q.push_back(32'h3);
        rx_data = 8'h11; rx_valid = 1'b1;
        wait_rhs(6, "pre_poll_timeout");
        tx_reg = 8'h77; irq_req++;
        finish_rx("pre_rx_timeout");
        repeat (5) @(negedge clk);
        chk("pre_rd5", rd_q[5], BASE + 32'h08);
        chk("pre_rd6", rd_q[6], BASE + 32'h04);
        chk("pre_rd7", rd_q[7], BASE + 32'h08);
        chk("pre_wr5", wr_q[5].addr, BASE + 32'h10);
        chk("pre_wr6", wr_q[6].data, 32'h11);
        chk("pre_tx", {24'd0, tx_q[tx_q.size()-1]}, 32'h77);

        // Write handshake ordering: W first then AW, and the reverse
        aw_delay = 3; w_delay = 0;
        do_rx(8'h66, "order1_timeout");
        aw_delay = 0; w_delay = 3;
        tx_reg = 8'h3C; irq_req++;
        wait_wr(9, "order2_timeout");
        repeat (5) @(negedge clk);
        chk("order1_data", wr_q[7].data, 32'h66);
        chk("order2_addr", wr_q[8].addr, BASE + 32'h10);
        chk("order_bcnt", b_cnt, wr_q.size());
        chk("order_proto", proto_err, 0);

        // Randomised traffic against a transaction-level model
        rd0 = rd_q.size(); wr0 = wr_q.size(); tx0 = tx_q.size();
        for (int i = 0; i < 24; i++) begin
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                tx_reg = b; irq_req++;
                exp_rd.push_back(BASE + 32'h04);
                exp_wr.push_back('{BASE + 32'h10, 32'h0, 4'hF});
                exp_tx.push_back(b);
                wait_wr(wr0 + exp_wr.size(), "rand_tx_timeout");
            end else begin
                busy = $urandom_range(0, 2);
                for (int k = 0; k < busy; k++) begin
                    status_q.push_back($urandom | 32'h1);
                    exp_rd.push_back(BASE + 32'h08);
                end
                status_q.push_back($urandom & 32'hFFFF_FFFE);
                exp_rd.push_back(BASE + 32'h08);
                exp_wr.push_back('{BASE, {24'h0, b}, 4'hF});
                do_rx(b, "rand_rx_timeout");
            end
        end
        repeat (10) @(negedge clk);
        chk("rand_rd_len", rd_q.size() - rd0, exp_rd.size());
        chk("rand_wr_len", wr_q.size() - wr0, exp_wr.size());
        chk("rand_tx_len", tx_q.size() - tx0, exp_tx.size());
        for (int k = 0; k < exp_rd.size(); k++) chk("rand_rd", rd_q[rd0+k], exp_rd[k]);
        for (int k = 0; k < exp_wr.size(); k++) begin
            chk("rand_wr_addr", wr_q[wr0+k].addr, exp_wr[k].addr);
            chk("rand_wr_data", wr_q[wr0+k].data, exp_wr[k].data);
        end
        for (int k = 0; k < exp_tx.size(); k++) chk("rand_tx", {24'd0, tx_q[tx0+k]}, {24'd0, exp_tx[k]});

        // Error response on a TX read: sticky flag, byte still delivered
        rresp_force = 2'b10; tx_reg = 8'h99; irq_req++;
        wait_wr(wr_q.size() + 1, "err_timeout");
        rresp_force = 2'b00;
        repeat (5) @(negedge clk);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_byte", {24'd0, tx_q[tx_q.size()-1]}, 32'h99);
        tx_reg = 8'h55; irq_req++;
        wait_wr(wr_q.size() + 1, "err2_timeout");
        repeat (5) @(negedge clk);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset while waiting in TX_R
        r_hold = 1'b1; tx_reg = 8'h21; irq_req++;
        t = 0;
        while (!rready && t < 2000) begin @(negedge clk); t++; end
        chk("mid_in_tx_r", {31'd0, rready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_err", {31'd0, err}, 32'd0);
        chk("mid_flags", {27'd0, tx_valid, arvalid, rready, awvalid, wvalid}, 32'd0);
        r_hold = 1'b0;
        wb = wr_q.size();
        rst_n = 1'b1;
        wait_wr(wb + 1, "mid_init_timeout");
        chk("mid_init_addr", wr_q[wb].addr, BASE + 32'h0C);
        chk("mid_init_data", wr_q[wb].data, 32'h1);
        wait_wr(wb + 2, "mid_tx_timeout");
        repeat (5) @(negedge clk);
        chk("mid_ack_addr", wr_q[wb+1].addr, BASE + 32'h10);
        chk("mid_tx_byte", {24'd0, tx_q[tx_q.size()-1]}, 32'h21);
        chk("final_bcnt", b_cnt, wr_q.size());
        chk("final_proto", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
